// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
// The ovf wire exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor diff = a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
`endif

  logic             ai, bi, dBit, brNext;
  logic [WIDTH-1:0] resNext;

  // Full-subtractor cell on the current LSB of the operand shift registers
  assign ai      = aSh_q[0];
  assign bi      = bSh_q[0];
  assign dBit    = ai ^ bi ^ br_q;
  assign brNext  = (~ai & bi) | (~(ai ^ bi) & br_q);
  assign resNext = {dBit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
    aMsb_d  = aMsb_q;
    bMsb_d  = bMsb_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          aSh_d   = bus.a;
          bSh_d   = bus.b;
          br_d    = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          aMsb_d  = bus.a[WIDTH-1];
          bMsb_d  = bus.b[WIDTH-1];
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        aSh_d = aSh_q >> 1;
        bSh_d = bSh_q >> 1;
        res_d = resNext;
        br_d  = brNext;
        cnt_d = cnt_q + CW'(1);
        // Only the fully assembled result is published, so diff never shows partial bits
        if (cnt_q == LAST) begin
          diff_d  = resNext;
          bout_d  = brNext;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (aMsb_q != bMsb_q) && (dBit != aMsb_q);
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
      aMsb_q  <= aMsb_d;
      bMsb_q  <= bMsb_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: an 8-bit and a 2-bit serial_subtractor against an
// integer-arithmetic reference model, covering directed and random operands.
module tb_serial_subtractor;
  localparam int W  = 8;
  localparam int WN = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W))  bus8 ();
  serial_subtractor_if #(.WIDTH(WN)) bus2 ();

  serial_subtractor #(.WIDTH(W))  dut       (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(WN)) dutNarrow (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer subtraction, borrow = negative result, overflow = signed range escape
  function automatic void refModel(input int width, input int a, input int b, input int bin,
                                   output int diff, output int bout, output int ovf);
    int r, sa, sb, sr, half;
    half = 1 << (width - 1);
    r    = a - b - bin;
    bout = (r < 0) ? 1 : 0;
    diff = r & ((1 << width) - 1);
    sa   = (a >= half) ? a - (1 << width) : a;
    sb   = (b >= half) ? b - (1 << width) : b;
    sr   = sa - sb - bin;
    ovf  = (sr < -half || sr > half - 1) ? 1 : 0;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input string tag);
    int busyCnt = 0;
    bit seen = 0;
    int eDiff, eBout, eOvf;
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int i = 0; i < W + 4 && !seen; i++) begin
      if (bus8.done) seen = 1;
      else begin
        if (bus8.busy) busyCnt++;
        @(negedge clk);
      end
    end
    refModel(W, int'(a), int'(b), int'(bin), eDiff, eBout, eOvf);
    checkOutput({tag, " done"}, 32'(seen), 32'd1);
    checkOutput({tag, " busyCycles"}, 32'(busyCnt), 32'(W));
    checkOutput({tag, " busyAtDone"}, 32'(bus8.busy), 32'd0);
    checkOutput({tag, " diff"}, 32'(bus8.diff), 32'(eDiff));
    checkOutput({tag, " bout"}, 32'(bus8.bout), 32'(eBout));
`ifdef SERIAL_SUB_OVF_EN
    checkOutput({tag, " ovf"}, 32'(bus8.ovf), 32'(eOvf));
`endif
    @(negedge clk);
    checkOutput({tag, " donePulse"}, 32'(bus8.done), 32'd0);
    checkOutput({tag, " diffHold"}, 32'(bus8.diff), 32'(eDiff));
  endtask

  task automatic applyStimulusNarrow(input logic [WN-1:0] a, input logic [WN-1:0] b, input logic bin);
    int busyCnt = 0;
    bit seen = 0;
    int eDiff, eBout, eOvf;
    string tag;
    tag = $sformatf("narrow a=%0d b=%0d bin=%0d", a, b, bin);
    @(negedge clk);
    bus2.a = a; bus2.b = b; bus2.bin = bin; bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int i = 0; i < WN + 4 && !seen; i++) begin
      if (bus2.done) seen = 1;
      else begin
        if (bus2.busy) busyCnt++;
        @(negedge clk);
      end
    end
    refModel(WN, int'(a), int'(b), int'(bin), eDiff, eBout, eOvf);
    checkOutput({tag, " done"}, 32'(seen), 32'd1);
    checkOutput({tag, " busyCycles"}, 32'(busyCnt), 32'(WN));
    checkOutput({tag, " diff"}, 32'(bus2.diff), 32'(eDiff));
    checkOutput({tag, " bout"}, 32'(bus2.bout), 32'(eBout));
`ifdef SERIAL_SUB_OVF_EN
    checkOutput({tag, " ovf"}, 32'(bus2.ovf), 32'(eOvf));
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCount, lastDone, firstDone, strayDone;
    bus8.start = 0; bus8.a = '0; bus8.b = '0; bus8.bin = 0;
    bus2.start = 0; bus2.a = '0; bus2.b = '0; bus2.bin = 0;

    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(bus8.busy), 32'd0);
    checkOutput("reset done", 32'(bus8.done), 32'd0);
    checkOutput("reset diff", 32'(bus8.diff), 32'd0);
    checkOutput("reset bout", 32'(bus8.bout), 32'd0);
    checkOutput("reset narrow diff", 32'(bus2.diff), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("reset ovf", 32'(bus8.ovf), 32'd0);
`endif
    rst_n = 1'b1;

    applyStimulus(8'h5A, 8'h23, 1'b0, "basic");
    applyStimulus(8'h00, 8'h01, 1'b0, "underflow");
    applyStimulus(8'h10, 8'h10, 1'b1, "equalBin");
    applyStimulus(8'h77, 8'h77, 1'b0, "equalZero");
    applyStimulus(8'h00, 8'h00, 1'b1, "zeroBin");

    // Start held high: back-to-back results, with a mid-RUN operand glitch that must be ignored
    doneCount = 0; lastDone = -1; firstDone = -1;
    @(negedge clk);
    bus8.a = 8'h09; bus8.b = 8'h04; bus8.bin = 0; bus8.start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 3) begin bus8.a = 8'hAA; bus8.b = 8'h11; end
      if (c == 4) begin bus8.a = 8'h09; bus8.b = 8'h04; end
      if (bus8.done) begin
        checkOutput("b2b diff", 32'(bus8.diff), 32'h05);
        checkOutput("b2b busyAtDone", 32'(bus8.busy), 32'd0);
        if (lastDone >= 0) checkOutput("b2b period", 32'(c - lastDone), 32'(W + 1));
        else firstDone = c;
        lastDone = c;
        doneCount++;
      end
    end
    bus8.start = 1'b0;
    checkOutput("b2b firstDone", 32'(firstDone), 32'(W));
    checkOutput("b2b doneCount", 32'(doneCount), 32'd4);
    repeat (W + 3) @(negedge clk);

    // Reset in the middle of a RUN aborts without a done pulse
    bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 32'(bus8.busy), 32'd0);
    checkOutput("abort done", 32'(bus8.done), 32'd0);
    checkOutput("abort diff", 32'(bus8.diff), 32'd0);
    checkOutput("abort bout", 32'(bus8.bout), 32'd0);
    rst_n = 1'b1;
    strayDone = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) strayDone++;
    end
    checkOutput("abort noDone", 32'(strayDone), 32'd0);
    applyStimulus(8'h03, 8'h01, 1'b0, "afterAbort");

    applyStimulus(8'h80, 8'h01, 1'b0, "ovfNegPos");
    applyStimulus(8'h7F, 8'hFF, 1'b0, "ovfPosNeg");
    applyStimulus(8'h05, 8'h03, 1'b0, "noOvf");

    for (int i = 0; i < 30; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int bin = 0; bin < 2; bin++)
          applyStimulusNarrow(2'(a), 2'(b), 1'(bin));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
